// File: rtl/lpc_phy_sched.sv
// Sample-slot scheduler between the LPC decoder and a 4-deep PCM output FIFO.
// Define LPC_SCHED_UNDERRUN_EN to build the missed-slot (underrun) counter.
module lpc_phy_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic [15:0] cfg_div,
  input  logic        phy_rd_valid,
  output logic        phy_rd,
  input  logic [1:0]  phy_rd_chansgn,
  input  logic [16:0] phy_rd_data_chan0,
  input  logic [16:0] phy_rd_data_chan1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] underrun_cnt
);

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARM, S_READ} state_t;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] l;
  } frame_t;

  state_t         state;
  logic [15:0]    div_cnt;
  logic           tick;
  logic           push, pop, full;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  frame_t         mem [DEPTH];
  frame_t         frame_in;

  // ---------------------------------------------------------------- divider
  // >= rather than == so a cfg_div lowered below the running count still
  // fires at the next compare instead of wrapping through 65535.
  assign tick = (state != S_IDLE) && cfg_en && (div_cnt >= cfg_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   div_cnt <= '0;
    else if (state == S_IDLE || !cfg_en || tick) div_cnt <= '0;
    else                                       div_cnt <= div_cnt + 16'd1;
  end

  // ---------------------------------------------------------- reconstruction
  logic [16:0] c0, c1, half, l17, r17;

  always_comb begin
    c0   = phy_rd_data_chan0;
    c1   = phy_rd_data_chan1;
    half = {1'b0, c1[16:1]};
    l17  = c0;
    r17  = c1;
    unique case (phy_rd_chansgn)
      2'd0: begin l17 = c0;      r17 = c1;      end
      2'd1: begin l17 = c0;      r17 = c0 - c1; end
      2'd2: begin l17 = c0 + c1; r17 = c1;      end
      default: begin
        r17 = c0 - half;
        l17 = c0 + half + {16'd0, c1[0]};
      end
    endcase
    frame_in = '{r: r17[15:0], l: l17[15:0]};
  end

  // -------------------------------------------------------------- scheduler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      phy_rd <= 1'b0;
    end else begin
      phy_rd <= 1'b0;
      unique case (state)
        S_IDLE: if (cfg_en) state <= S_WAIT;
        S_WAIT: begin
          if (!cfg_en)   state <= S_IDLE;
          else if (tick) state <= S_ARM;
        end
        S_ARM: begin
          if (!cfg_en) state <= S_IDLE;
          else if (phy_rd_valid && !full) begin
            state  <= S_READ;
            phy_rd <= 1'b1;
          end
        end
        S_READ: begin
          // capture completes this edge even if cfg_en has just dropped
          if (!cfg_en)                   state <= S_IDLE;
          else if (phy_rd_valid && !tick) state <= S_WAIT;
          else                           state <= S_ARM;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ output FIFO
  // Space is checked in ARM; only READ pushes, so no overflow is possible.
  assign push      = (state == S_READ) && phy_rd_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == (AW+1)'(DEPTH));
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= frame_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // -------------------------------------------------------- underrun count
`ifdef LPC_SCHED_UNDERRUN_EN
  logic [15:0] urun_q;
  logic        urun_inc;

  // a served READ that coincides with a tick opens a fresh slot, not a miss
  assign urun_inc = tick && ((state == S_ARM) || (state == S_READ && !phy_rd_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              urun_q <= '0;
    else if (urun_inc && urun_q != 16'hFFFF) urun_q <= urun_q + 16'd1;
  end

  assign underrun_cnt = urun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_lpc_phy_sched.sv
// Scoreboard bench for lpc_phy_sched: expected frames queued on each READ,
// compared when the FIFO head is consumed.
module tb_lpc_phy_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_div = '0;
  logic        phy_rd_valid = 1'b0;
  logic        phy_rd;
  logic [1:0]  phy_rd_chansgn = '0;
  logic [16:0] phy_rd_data_chan0 = '0;
  logic [16:0] phy_rd_data_chan1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [15:0] underrun_cnt;

  lpc_phy_sched dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_div(cfg_div),
    .phy_rd_valid(phy_rd_valid), .phy_rd(phy_rd), .phy_rd_chansgn(phy_rd_chansgn),
    .phy_rd_data_chan0(phy_rd_data_chan0), .phy_rd_data_chan1(phy_rd_data_chan1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int          nvec = 0, nerr = 0;
  logic [31:0] q[$];
  int          cyc = 0, rd_total = 0, pop_total = 0, last_rd = -1, per_exp = 0;
  bit          prev_push = 0, prev_rd = 0, lit_en = 0;
  logic [31:0] lit_exp = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] m, input logic [16:0] a, input logic [16:0] b);
    logic [16:0] l, r;
    case (m)
      2'd0:    begin l = a;     r = b;     end
      2'd1:    begin l = a;     r = a - b; end
      2'd2:    begin l = a + b; r = b;     end
      default: begin r = a - (b >> 1); l = a + (b >> 1) + {16'd0, b[0]}; end
    endcase
    return {r[15:0], l[15:0]};
  endfunction

  // monitor: inputs change at posedge+1, everything is sampled at negedge
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (per_exp == 0) last_rd = -1;
    if (rst) begin
      q.delete();
      prev_push = 0;
      prev_rd   = 0;
    end else begin
      if (prev_push) chk("latency", 32'(out_valid), 32'd1);
      if (prev_rd)   chk("rd_single", 32'(phy_rd), 32'd0);
      if (out_valid && out_ready) begin
        pop_total++;
        if (q.size() == 0) chk("sb_empty_pop", 32'd0, 32'd1);
        else begin
          e = q.pop_front();
          chk("frame", out_data, e);
          if (lit_en) chk("lit", out_data, lit_exp);
        end
      end
      if (phy_rd) begin
        rd_total++;
        if (per_exp > 0 && last_rd >= 0) chk("period", 32'(cyc - last_rd), 32'(per_exp));
        last_rd = cyc;
      end
      prev_rd   = phy_rd;
      prev_push = phy_rd && phy_rd_valid;
      if (prev_push) q.push_back(model(phy_rd_chansgn, phy_rd_data_chan0, phy_rd_data_chan1));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rnd_data();
    phy_rd_chansgn    = 2'($urandom);
    phy_rd_data_chan0 = 17'($urandom);
    phy_rd_data_chan1 = 17'($urandom);
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!phy_rd && n < 500);
  endtask

  task automatic lit_case(input logic [1:0] m, input logic [16:0] a, input logic [16:0] b,
                          input logic [31:0] exp);
    int p, k;
    phy_rd_valid = 1'b0;
    repeat (20) step();
    chk("drained", 32'(out_valid), 32'd0);
    phy_rd_chansgn = m; phy_rd_data_chan0 = a; phy_rd_data_chan1 = b;
    lit_exp = exp; lit_en = 1;
    p = pop_total; k = 0;
    phy_rd_valid = 1'b1;
    while (pop_total < p + 2 && k < 200) begin step(); k++; end
    chk("lit_pops", 32'(pop_total - p >= 2), 32'd1);
    phy_rd_valid = 1'b0;
    repeat (6) step();
    lit_en = 0;
  endtask

  initial begin
    int n, r, p;
    logic [15:0] u1, u2;

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_phy_rd", 32'(phy_rd), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);

    // steady pacing with cfg_div=50
    step(); step();
    rnd_data();
    cfg_div = 16'd50; phy_rd_valid = 1'b1; out_ready = 1'b1; cfg_en = 1'b1; rst = 1'b0;
    wait_rd(n);
    chk("first_tick", 32'(n), 32'd54);
    per_exp = 51;
    step();
    repeat (4 * 51 + 5) begin step(); rnd_data(); end
    per_exp = 0;

    // reconstruction literals
    cfg_div = 16'd3;
    lit_case(2'd3, 17'h00100, 17'h00005, 32'h00FE0103);
    lit_case(2'd1, 17'd10, 17'd3, 32'h0007000A);
    lit_case(2'd2, 17'h1FFFF, 17'h00002, 32'h00020001);
    lit_case(2'd0, 17'h12345, 17'h0ABCD, 32'hABCD2345);

    // back-pressure fill: cfg_div=0, sink stalled
    cfg_en = 1'b0; repeat (3) step();
    out_ready = 1'b0; cfg_div = 16'd0; phy_rd_valid = 1'b1; rnd_data();
    r = rd_total;
    cfg_en = 1'b1;
    repeat (30) begin step(); rnd_data(); end
    chk("fill_reads", 32'(rd_total - r), 32'd4);
    chk("full_valid", 32'(out_valid), 32'd1);
    @(negedge clk); u1 = underrun_cnt;
    @(negedge clk); u2 = underrun_cnt;
`ifdef LPC_SCHED_UNDERRUN_EN
    chk("urun_per_cycle", 32'(u2 - u1), 32'd1);
`else
    chk("urun_zero", 32'(u2), 32'd0);
`endif
    step();
    r = rd_total;
    repeat (10) step();
    chk("no_rd_full", 32'(rd_total - r), 32'd0);

    // single pop pulse while full: exactly one refill read, nothing lost
    r = rd_total; p = pop_total;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    repeat (5) step();
    chk("refill_reads", 32'(rd_total - r), 32'd1);
    chk("one_pop", 32'(pop_total - p), 32'd1);
    phy_rd_valid = 1'b0; repeat (3) step();
    p = pop_total; out_ready = 1'b1;
    repeat (10) step();
    chk("drain4", 32'(pop_total - p), 32'd4);
    chk("sb_empty_drain", 32'(q.size()), 32'd0);

    // missed slots: valid low across three ticks at cfg_div=9
    rst = 1'b1; step(); step();
    cfg_div = 16'd9; phy_rd_valid = 1'b0; cfg_en = 1'b1; rst = 1'b0;
    repeat (35) step();
    r = rd_total;
    phy_rd_valid = 1'b1;
    repeat (4) step();
`ifdef LPC_SCHED_UNDERRUN_EN
    chk("urun_two", 32'(underrun_cnt), 32'd2);
`else
    chk("urun_off", 32'(underrun_cnt), 32'd0);
`endif
    chk("one_read", 32'(rd_total - r), 32'd1);

    // reset pulse landing on a READ cycle
    wait_rd(n);
    chk("rd_seen", 32'(phy_rd), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_phy_rd", 32'(phy_rd), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", out_data, 32'd0);
    chk("rst_mid_urun", 32'(underrun_cnt), 32'd0);
    step(); step();
    rst = 1'b0;
    wait_rd(n);
    chk("first_tick_rst", 32'(n), 32'd13);
    step();

    // random traffic with back-pressure, divider and enable changes
    repeat (600) begin
      step();
      rnd_data();
      phy_rd_valid = ($urandom_range(3) != 0);
      out_ready    = ($urandom_range(2) != 0);
      if ($urandom_range(40) == 0) cfg_div = 16'($urandom_range(4));
      if ($urandom_range(60) == 0) cfg_en = ~cfg_en;
    end
    phy_rd_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    chk("final_sb_empty", 32'(q.size()), 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
